// File: rtl/pp_tree_reduce_pipe_if.sv
// Handshake and data bundle for the pipelined partial-product reduction tree.
interface pp_tree_reduce_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_mode;
    logic [WIDTH*WIDTH-1:0]   in_pp;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*WIDTH-1:0]       out_res;
    logic [2*WIDTH-1:0]       out_err;
    logic                     out_mode;
    logic                     busy;

    modport master (
        output in_valid, in_mode, in_pp, out_ready,
        input  in_ready, out_valid, out_res, out_err, out_mode, busy
    );

    modport slave (
        input  in_valid, in_mode, in_pp, out_ready,
        output in_ready, out_valid, out_res, out_err, out_mode, busy
    );
endinterface

// File: rtl/pp_tree_reduce_pipe.sv
// Pipelined partial-product reduction tree, one tree level per register stage.
// Low levels may OR-compress per beat; the dropped carries travel along as err.
module pp_tree_reduce_pipe #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned APPROX_LEVELS = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    pp_tree_reduce_pipe_if.slave bus
);
    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned W2     = 2 * WIDTH;
    localparam int unsigned NE     = WIDTH - 1;

    // All stored tree elements packed triangularly: level l starts at WIDTH - (WIDTH >> (l-1)).
    logic [W2-1:0] r_e     [NE];
    logic [W2-1:0] w_e     [NE];
    logic [W2-1:0] r_err   [LEVELS];
    logic [W2-1:0] w_err   [LEVELS];
    logic          r_mode  [LEVELS];
    logic          w_mode  [LEVELS];
    logic          r_valid [LEVELS];
    logic          w_load  [LEVELS];
    logic          w_busy;

    always_comb begin : comb_tree
        logic [W2-1:0] v_a;
        logic [W2-1:0] v_b;
        logic [W2-1:0] v_err;
        logic          v_mode;
        logic          v_apx;
        int unsigned   v_n;
        int unsigned   v_base;
        int unsigned   v_pbase;
        w_e = '{default: '0};
        for (int unsigned s = 0; s < LEVELS; s++) begin
            v_n     = WIDTH >> (s + 1);
            v_base  = WIDTH - (WIDTH >> s);
            v_pbase = 0;
            if (s == 0) begin
                v_mode = bus.in_mode;
                v_err  = '0;
            end else begin
                v_mode  = r_mode[s-1];
                v_err   = r_err[s-1];
                v_pbase = WIDTH - (WIDTH >> (s - 1));
            end
            v_apx = v_mode && (s < APPROX_LEVELS);
            for (int unsigned j = 0; j < v_n; j++) begin
                if (s == 0) begin
                    v_a = {{WIDTH{1'b0}}, bus.in_pp[(2*j)*WIDTH +: WIDTH]};
                    v_b = {{WIDTH{1'b0}}, bus.in_pp[(2*j+1)*WIDTH +: WIDTH]};
                end else begin
                    v_a = r_e[v_pbase + 2*j];
                    v_b = r_e[v_pbase + 2*j + 1];
                end
                v_b = v_b << (1 << s);
                if (v_apx) begin
                    w_e[v_base + j] = v_a | v_b;
                    // Carries lost by the OR, placed at the absolute weight of a.
                    v_err = v_err + ((v_a & v_b) << (j << (s + 1)));
                end else begin
                    w_e[v_base + j] = v_a + v_b;
                end
            end
            w_err[s]  = v_err;
            w_mode[s] = v_mode;
        end
    end

    // Bubble-collapsing stall: a stage loads when empty or when its successor moves on.
    always_comb begin : comb_load
        logic v_next;
        v_next = bus.out_ready;
        for (int unsigned k = 0; k < LEVELS; k++) begin
            v_next = !r_valid[LEVELS-1-k] || v_next;
            w_load[LEVELS-1-k] = v_next;
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int unsigned s = 0; s < LEVELS; s++) begin
            w_busy = w_busy | r_valid[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < LEVELS; s++) begin
                r_valid[s] <= 1'b0;
                r_mode[s]  <= 1'b0;
                r_err[s]   <= '0;
            end
            for (int unsigned i = 0; i < NE; i++) begin
                r_e[i] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < LEVELS; s++) begin
                if (w_load[s]) begin
                    if (s == 0) begin
                        r_valid[s] <= bus.in_valid;
                    end else begin
                        r_valid[s] <= r_valid[s-1];
                    end
                    r_mode[s] <= w_mode[s];
                    r_err[s]  <= w_err[s];
                    for (int unsigned j = 0; j < (WIDTH >> (s + 1)); j++) begin
                        r_e[WIDTH - (WIDTH >> s) + j] <= w_e[WIDTH - (WIDTH >> s) + j];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_valid[LEVELS-1];
    assign bus.out_res   = r_e[NE-1];
    assign bus.out_err   = r_err[LEVELS-1];
    assign bus.out_mode  = r_mode[LEVELS-1];
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_pp_tree_reduce_pipe.sv
// Bench for pp_tree_reduce_pipe: vector table, scoreboard queue, stall/reset sequences.
module tb_pp_tree_reduce_pipe;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AL    = 1;

    typedef struct {
        logic [15:0] res;
        logic [15:0] err;
        logic        mode;
    } sb_t;

    typedef struct {
        logic [63:0] pp;
        logic        mode;
        logic [15:0] res;
        logic [15:0] err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    sb_t  q[$];
    vec_t tbl[9];

    pp_tree_reduce_pipe_if #(.WIDTH(WIDTH)) bus ();

    pp_tree_reduce_pipe #(
        .WIDTH         (WIDTH),
        .APPROX_LEVELS (AL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: OR/add tree for res, exact weighted sum for err = exact - res.
    function automatic sb_t model(input logic [63:0] pp, input logic m);
        logic [15:0] e [8];
        logic [15:0] exact;
        logic [15:0] a;
        logic [15:0] b;
        int unsigned n;
        sb_t r;
        exact = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            e[i]  = {8'h00, pp[i*8 +: 8]};
            exact = exact + (e[i] << i);
        end
        n = 8;
        for (int unsigned l = 1; l <= 3; l++) begin
            for (int unsigned j = 0; j < n / 2; j++) begin
                a = e[2*j];
                b = e[2*j+1] << (1 << (l - 1));
                e[j] = (m && l <= AL) ? (a | b) : (a + b);
            end
            n = n / 2;
        end
        r.res  = e[0];
        r.err  = exact - e[0];
        r.mode = m;
        return r;
    endfunction

    task automatic cyc(input logic v, input logic [63:0] pp, input logic m, input logic rdy,
                       input sb_t e, output logic acc, output logic ov);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_pp     = pp;
        bus.in_mode   = m;
        bus.out_ready = rdy;
        #1;
        acc = v && bus.in_ready;
        ov  = bus.out_valid;
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got out_valid=1 expected no pending beat");
            end else begin
                chk("out_res", bus.out_res, q[0].res);
                chk("out_err", bus.out_err, q[0].err);
                chk("out_mode", bus.out_mode, q[0].mode);
                if (rdy) void'(q.pop_front());
            end
        end
        if (acc) q.push_back(e);
    endtask

    task automatic beat(input logic v, input logic [63:0] pp, input logic m, input logic rdy,
                        output logic acc, output logic ov);
        cyc(v, pp, m, rdy, model(pp, m), acc, ov);
    endtask

    task automatic idle(output logic ov);
        logic acc;
        beat(1'b0, 64'h0, 1'b0, 1'b1, acc, ov);
    endtask

    task automatic drain();
        logic ov;
        int   k;
        k = 0;
        while (q.size() != 0 && k < 20) begin
            idle(ov);
            k++;
        end
        idle(ov);
        chk("drain_empty", q.size(), 0);
        chk("drain_busy", bus.busy, 0);
    endtask

    task automatic latency(input logic [63:0] pp, input logic m);
        logic acc;
        logic ov;
        int   lat;
        beat(1'b1, pp, m, 1'b1, acc, ov);
        chk("lat_accept", acc, 1);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            idle(ov);
            if (ov && lat == 0) lat = k;
        end
        chk("latency", lat, 3);
    endtask

    initial begin
        logic        acc;
        logic        ov;
        logic [63:0] pp;
        logic        m;
        logic [63:0] p4 [4];
        logic        acc_exp [4];

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 16'hFE01, 16'h0000};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16'hA9AB, 16'h5456};
        tbl[2] = '{64'h0000_0000_0000_0000, 1'b1, 16'h0000, 16'h0000};
        tbl[3] = '{64'h0000_0000_0000_0101, 1'b1, 16'h0003, 16'h0000};
        tbl[4] = '{64'h0000_0000_0000_0102, 1'b1, 16'h0002, 16'h0002};
        tbl[5] = '{64'h0000_0000_0000_0102, 1'b0, 16'h0004, 16'h0000};
        tbl[6] = '{64'h0000_0000_0000_4080, 1'b1, 16'h0080, 16'h0080};
        tbl[7] = '{64'hFF00_0000_0000_0000, 1'b1, 16'h7F80, 16'h0000};
        tbl[8] = '{64'h0000_0000_0003_0003, 1'b1, 16'h000F, 16'h0000};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pp     = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_res", bus.out_res, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_out_mode", bus.out_mode, 0);
        @(negedge clk);
        rst_n = 1'b1;

        latency(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        drain();

        foreach (tbl[i]) begin
            cyc(1'b1, tbl[i].pp, tbl[i].mode, 1'b1, '{tbl[i].res, tbl[i].err, tbl[i].mode}, acc, ov);
            chk("tbl_accept", acc, 1);
        end
        drain();

        for (int i = 0; i < 1000; i++) begin
            pp = {$urandom, $urandom};
            m  = 1'($urandom_range(0, 1));
            beat(1'b1, pp, m, 1'b1, acc, ov);
            chk("b2b_accept", acc, 1);
            if (i >= 3) chk("b2b_out_valid", ov, 1);
        end
        drain();

        acc_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            p4[i] = {$urandom, $urandom};
            beat(1'b1, p4[i], 1'(i % 2), 1'b0, acc, ov);
            chk("stall_accept", acc, acc_exp[i]);
        end
        chk("stall_out_valid", ov, 1);
        chk("stall_busy", bus.busy, 1);
        beat(1'b1, p4[3], 1'b1, 1'b1, acc, ov);
        chk("stall_release_accept", acc, 1);
        drain();

        for (int i = 0; i < 400; i++) begin
            pp = {$urandom, $urandom};
            m  = 1'($urandom_range(0, 1));
            beat(1'($urandom_range(0, 1)), pp, m, 1'($urandom_range(0, 1)), acc, ov);
        end
        drain();

        beat(1'b1, {$urandom, $urandom}, 1'b1, 1'b1, acc, ov);
        beat(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, acc, ov);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("inflight_rst_out_valid", bus.out_valid, 0);
        chk("inflight_rst_busy", bus.busy, 0);
        chk("inflight_rst_out_res", bus.out_res, 0);
        chk("inflight_rst_out_err", bus.out_err, 0);
        chk("inflight_rst_out_mode", bus.out_mode, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        latency({$urandom, $urandom}, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
